// File: rtl/ahb_sim_ctrl_pkg.sv
// Shared constants and types for the simulation-control AHB-Lite responder.
package ahb_sim_ctrl_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned OFFS_W = 12;
  localparam int unsigned CHAR_W = 8;

  localparam logic [OFFS_W-1:0] OFFS_STATUS   = 12'hFF0;
  localparam logic [OFFS_W-1:0] OFFS_FIFOSTAT = 12'hFF4;
  localparam logic [OFFS_W-1:0] OFFS_CONSOLE  = 12'hFF8;
  localparam logic [OFFS_W-1:0] OFFS_TIMER    = 12'hFFC;

  localparam logic [DATA_W-1:0] PASS_LO = 32'h0000_0FFF;
  localparam logic [DATA_W-1:0] PASS_HI = 32'hFFFF_0000;
  localparam logic [DATA_W-1:0] FAIL_LO = 32'h0000_0EEE;
  localparam logic [DATA_W-1:0] FAIL_HI = 32'hEEEE_0000;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic [1:0] HRESP_OKAY = 2'b00;

  localparam int unsigned STAT_PASS = 0;
  localparam int unsigned STAT_FAIL = 1;
  localparam int unsigned STAT_HANG = 2;

  typedef enum logic [1:0] {
    CON_CHAR = 2'd0,
    CON_PASS = 2'd1,
    CON_FAIL = 2'd2
  } console_e;

  // Registered AHB address phase, consumed in the following data phase.
  typedef struct packed {
    logic              valid;
    logic              write;
    logic [OFFS_W-1:0] offset;
  } dphase_t;

  // Terminal magic values take precedence; anything else is a character.
  function automatic console_e classify(input logic [DATA_W-1:0] data);
    console_e kind;
    kind = CON_CHAR;
    if (data == PASS_LO || data == PASS_HI) begin
      kind = CON_PASS;
    end else if (data == FAIL_LO || data == FAIL_HI) begin
      kind = CON_FAIL;
    end
    return kind;
  endfunction

endpackage

// File: rtl/ahb_sim_ctrl_slave_fifo.sv
// Console character FIFO: power-of-two depth, push accepted when full if a pop
// happens in the same cycle, head data masked to zero when empty.
module sim_ctrl_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_b,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Storage array needs no reset; the head is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ahb_sim_ctrl_slave.sv
// AHB-Lite simulation-control responder: console FIFO, sticky pass/fail flags,
// saturating virtual-time counter and retire-inactivity watchdog.
module ahb_sim_ctrl_slave
  import ahb_sim_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h6000_F000,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned HANG_CYCLES = 5000
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              hsel,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [DATA_W-1:0] hwdata,
  input  logic              hready,
  output logic              hreadyout,
  output logic [1:0]        hresp,
  output logic [DATA_W-1:0] hrdata,
  input  logic              retire,
  output logic              char_valid,
  output logic [CHAR_W-1:0] char_data,
  input  logic              char_ready,
  output logic              sim_pass,
  output logic              sim_fail,
  output logic              sim_hang
);

  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned IDLE_W = $clog2(HANG_CYCLES + 1);

  dphase_t           dp_q;
  logic              addr_hit;
  logic              console_wr;
  console_e          console_kind;
  logic              char_wr;
  logic              fifo_push;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic              pass_set;
  logic              fail_set;
  logic [DATA_W-1:0] timer_q;
  logic [IDLE_W-1:0] idle_q;
  logic              watchdog_frozen;
  logic              unused_hsize;

  assign unused_hsize = ^hsize;

  // Address phase qualification: selected, ready, active transfer, in window.
  assign addr_hit = hsel & hready
                  & ((htrans == HTRANS_NONSEQ) | (htrans == HTRANS_SEQ))
                  & (haddr[ADDR_W-1:OFFS_W] == BASE_ADDR[ADDR_W-1:OFFS_W]);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      dp_q <= '0;
    end else if (hready) begin
      dp_q <= '{valid: addr_hit, write: hwrite, offset: haddr[OFFS_W-1:0]};
    end
  end

  // Data-phase console decode; only character writes can stall on a full FIFO.
  assign console_wr   = dp_q.valid & dp_q.write & (dp_q.offset == OFFS_CONSOLE);
  assign console_kind = classify(hwdata);
  assign char_wr      = console_wr & (console_kind == CON_CHAR);
  assign fifo_push    = char_wr & ~fifo_full;
  assign hreadyout    = ~(char_wr & fifo_full);
  assign hresp        = HRESP_OKAY;

  // First terminal write wins; later ones are ignored.
  assign pass_set = console_wr & (console_kind == CON_PASS) & ~sim_pass & ~sim_fail;
  assign fail_set = console_wr & (console_kind == CON_FAIL) & ~sim_pass & ~sim_fail;

  sim_ctrl_fifo #(
    .WIDTH (CHAR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_b (rst_b),
    .push  (fifo_push),
    .wdata (hwdata[CHAR_W-1:0]),
    .pop   (char_ready),
    .rdata (char_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign char_valid = ~fifo_empty;

  always_comb begin
    hrdata = '0;
    if (dp_q.valid && !dp_q.write) begin
      case (dp_q.offset)
        OFFS_STATUS: begin
          hrdata[STAT_PASS] = sim_pass;
          hrdata[STAT_FAIL] = sim_fail;
          hrdata[STAT_HANG] = sim_hang;
        end
        OFFS_FIFOSTAT: hrdata = {23'd0, fifo_full, 8'(fifo_count)};
        OFFS_TIMER:    hrdata = timer_q;
        default:       hrdata = '0;
      endcase
    end
  end

  // Saturating virtual-time counter.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      timer_q <= '0;
    end else if (timer_q != '1) begin
      timer_q <= timer_q + DATA_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      sim_pass <= 1'b0;
      sim_fail <= 1'b0;
    end else begin
      if (pass_set) begin
        sim_pass <= 1'b1;
      end
      if (fail_set) begin
        sim_fail <= 1'b1;
      end
    end
  end

  // Watchdog stops counting once any completion flag is raised.
  assign watchdog_frozen = sim_pass | sim_fail | sim_hang;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      idle_q   <= '0;
      sim_hang <= 1'b0;
    end else if (!watchdog_frozen) begin
      if (retire) begin
        idle_q <= '0;
      end else if (idle_q == IDLE_W'(HANG_CYCLES - 1)) begin
        sim_hang <= 1'b1;
      end else begin
        idle_q <= idle_q + IDLE_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ahb_sim_ctrl_slave.sv
// Directed bench for ahb_sim_ctrl_slave with hand-computed expectations.
module tb_ahb_sim_ctrl_slave;

  localparam logic [31:0] A_STATUS   = 32'h6000_FFF0;
  localparam logic [31:0] A_FIFOSTAT = 32'h6000_FFF4;
  localparam logic [31:0] A_CONSOLE  = 32'h6000_FFF8;
  localparam logic [31:0] A_TIMER    = 32'h6000_FFFC;
  localparam logic [31:0] A_BASE     = 32'h6000_F000;
  localparam logic [31:0] A_HOLE     = 32'h6000_F100;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        hsel = 1'b0;
  logic [31:0] haddr = '0;
  logic [1:0]  htrans = 2'b00;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'b010;
  logic [31:0] hwdata = '0;
  logic        hready;
  logic        hreadyout;
  logic [1:0]  hresp;
  logic [31:0] hrdata;
  logic        retire = 1'b0;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        char_ready = 1'b0;
  logic        sim_pass;
  logic        sim_fail;
  logic        sim_hang;

  int n_checks = 0;
  int n_errors = 0;

  assign hready = hreadyout;

  always #5 clk = ~clk;

  ahb_sim_ctrl_slave dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .hsel       (hsel),
    .haddr      (haddr),
    .htrans     (htrans),
    .hwrite     (hwrite),
    .hsize      (hsize),
    .hwdata     (hwdata),
    .hready     (hready),
    .hreadyout  (hreadyout),
    .hresp      (hresp),
    .hrdata     (hrdata),
    .retire     (retire),
    .char_valid (char_valid),
    .char_data  (char_data),
    .char_ready (char_ready),
    .sim_pass   (sim_pass),
    .sim_fail   (sim_fail),
    .sim_hang   (sim_hang)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_b = 1'b0;
    hsel = 1'b0;
    htrans = 2'b00;
    hwrite = 1'b0;
    retire = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Drives one address phase; returns #1 after the sampling edge.
  task automatic addr_phase(input logic [31:0] a, input logic w);
    hsel = 1'b1;
    haddr = a;
    htrans = 2'b10;
    hwrite = w;
    @(posedge clk);
    #1;
    hsel = 1'b0;
    htrans = 2'b00;
    hwrite = 1'b0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bit done;
    done = 1'b0;
    addr_phase(a, 1'b1);
    hwdata = d;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      done = hreadyout;
      @(posedge clk);
      #1;
    end
    check("write_done", 32'(done), 32'd1);
  endtask

  task automatic check_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr_phase(a, 1'b0);
    @(negedge clk);
    check(tag, hrdata, exp);
    check({tag, "_resp"}, 32'(hresp), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    addr_phase(a, 1'b0);
    @(negedge clk);
    d = hrdata;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] t0, t1;

  initial begin
    // Values while reset is held.
    #1;
    check("rst_hreadyout", 32'(hreadyout), 32'd1);
    check("rst_hrdata", hrdata, 32'd0);
    check("rst_hresp", 32'(hresp), 32'd0);
    check("rst_char_valid", 32'(char_valid), 32'd0);
    check("rst_char_data", 32'(char_data), 32'd0);
    check("rst_flags", 32'({sim_hang, sim_fail, sim_pass}), 32'd0);

    // Watchdog with retire held low from reset release.
    rst_b = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    repeat (4999) @(posedge clk);
    @(negedge clk);
    check("hang_4999", 32'(sim_hang), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("hang_5000", 32'(sim_hang), 32'd1);
    @(posedge clk);
    #1;
    check_read("status_hang", A_STATUS, 32'h4);

    // Retire pulse in the last idle cycle restarts the count.
    rst_b = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    repeat (4999) @(posedge clk);
    #1 retire = 1'b1;
    @(posedge clk);
    #1 retire = 1'b0;
    @(negedge clk);
    check("hang_retired", 32'(sim_hang), 32'd0);
    repeat (4999) @(posedge clk);
    @(negedge clk);
    check("hang_restart_4999", 32'(sim_hang), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("hang_restart_5000", 32'(sim_hang), 32'd1);

    // Two pipelined character writes drain on consecutive cycles.
    do_reset();
    char_ready = 1'b1;
    addr_phase(A_CONSOLE, 1'b1);
    hwdata = 32'h41;
    hsel = 1'b1; haddr = A_CONSOLE; htrans = 2'b10; hwrite = 1'b1;
    @(negedge clk);
    check("chr1_ready", 32'(hreadyout), 32'd1);
    @(posedge clk);
    #1;
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = 32'h42;
    @(negedge clk);
    check("chr1_valid", 32'(char_valid), 32'd1);
    check("chr1_data", 32'(char_data), 32'h41);
    check("chr2_ready", 32'(hreadyout), 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("chr2_valid", 32'(char_valid), 32'd1);
    check("chr2_data", 32'(char_data), 32'h42);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("chr_drained", 32'(char_valid), 32'd0);
    @(posedge clk);
    #1;

    // Timer deltas and saturation.
    bus_read(A_TIMER, t0);
    repeat (8) @(posedge clk);
    #1;
    bus_read(A_TIMER, t1);
    check("timer_delta", t1 - t0, 32'd10);
    force dut.timer_q = 32'hFFFF_FFFE;
    repeat (2) @(posedge clk);
    #1 release dut.timer_q;
    repeat (3) @(posedge clk);
    #1;
    check_read("timer_sat", A_TIMER, 32'hFFFF_FFFF);
    check_read("console_rd", A_CONSOLE, 32'd0);
    check_read("hole_rd", A_HOLE, 32'd0);

    // Fill the FIFO with the consumer stalled.
    char_ready = 1'b0;
    for (int i = 0; i < 8; i++) bus_write(A_CONSOLE, 32'h30 + 32'(i));
    check_read("fifostat_full", A_FIFOSTAT, 32'h108);

    // Terminal write on a full FIFO never stalls.
    addr_phase(A_CONSOLE, 1'b1);
    hwdata = 32'hFFFF_0000;
    @(negedge clk);
    check("term_no_stall", 32'(hreadyout), 32'd1);
    check("pass_before", 32'(sim_pass), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("pass_after", 32'(sim_pass), 32'd1);
    @(posedge clk);
    #1;

    // Ninth character stalls until one pop frees a slot.
    addr_phase(A_CONSOLE, 1'b1);
    hwdata = 32'h38;
    @(negedge clk);
    check("stall_0", 32'(hreadyout), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("stall_1", 32'(hreadyout), 32'd0);
    @(posedge clk);
    #1 char_ready = 1'b1;
    @(negedge clk);
    check("stall_pop", 32'(hreadyout), 32'd0);
    check("stall_head", 32'(char_data), 32'h30);
    @(posedge clk);
    #1 char_ready = 1'b0;
    @(negedge clk);
    check("stall_release", 32'(hreadyout), 32'd1);
    @(posedge clk);
    #1;
    check_read("fifostat_refill", A_FIFOSTAT, 32'h108);

    // Later terminal write is ignored.
    bus_write(A_CONSOLE, 32'h0000_0EEE);
    @(negedge clk);
    check("fail_ignored", 32'(sim_fail), 32'd0);
    @(posedge clk);
    #1;
    check_read("status_pass", A_STATUS, 32'h1);
    bus_write(A_STATUS, 32'hFFFF_FFFF);
    check_read("status_ro", A_STATUS, 32'h1);

    // Drain and check order, including the character pushed after PASS.
    char_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("drain_valid", 32'(char_valid), 32'd1);
      check("drain_data", 32'(char_data), 32'h31 + 32'(i));
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("drain_empty", 32'(char_valid), 32'd0);
    @(posedge clk);
    #1;
    char_ready = 1'b0;

    // Reset asserted in the middle of a full-FIFO stall.
    for (int i = 0; i < 8; i++) bus_write(A_CONSOLE, 32'h50 + 32'(i));
    addr_phase(A_CONSOLE, 1'b1);
    hwdata = 32'h58;
    @(negedge clk);
    check("rstall_stall", 32'(hreadyout), 32'd0);
    #2 rst_b = 1'b0;
    #1;
    check("rstall_ready", 32'(hreadyout), 32'd1);
    check("rstall_valid", 32'(char_valid), 32'd0);
    check("rstall_flags", 32'({sim_hang, sim_fail, sim_pass}), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    @(posedge clk);
    #1;
    check_read("base_rd", A_BASE, 32'd0);
    check_read("fifostat_rst", A_FIFOSTAT, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
